// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic pipe unit: opcode width, opcode enum and
// a small helper that classifies rotate opcodes.
// Optional feature macro: LOGIC_PIPE_ROTATE_EN (enables ROL/ROR opcodes).
package logic_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } op_e;

  // True for the two rotate opcodes, which exist only in the rotate build.
  function automatic logic op_is_rotate(input logic [OP_W-1:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/lu_logic_core.sv
// Combinational opcode decode for the logic pipe unit. Produces a DATA_W
// result and an illegal flag. Rotates rotate operand a by b modulo DATA_W.
// Optional feature macro: LOGIC_PIPE_ROTATE_EN. Without it, ROL/ROR return
// zero and raise illegal.
module lu_logic_core
  import logic_pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

`ifdef LOGIC_PIPE_ROTATE_EN
  localparam int AMT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [AMT_W-1:0]    amt_raw;
  int                  amt;
  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   rol_val;
  logic [DATA_W-1:0]   ror_val;

  // Rotate by doubling the operand and shifting; amount wraps modulo DATA_W
  // so non-power-of-two widths still rotate correctly.
  always_comb begin
    amt_raw = b[AMT_W-1:0];
    amt     = int'(amt_raw) % DATA_W;
    dbl     = {a, a};
    rol_val = DATA_W'((dbl << amt) >> DATA_W);
    ror_val = DATA_W'(dbl >> amt);
  end
`endif

  // Opcode decode; illegal is only ever raised for rotates in the plain build.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
`ifdef LOGIC_PIPE_ROTATE_EN
      OP_ROL:  result = rol_val;
      OP_ROR:  result = ror_val;
`else
      OP_ROL, OP_ROR: begin
        result  = '0;
        illegal = op_is_rotate(op);
      end
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_pipe_unit.sv
// Two-stage bitwise logic / rotate pipeline with valid/ready handshakes.
// S1 registers the operands and opcode, S2 registers the decoded result,
// its zero flag and the illegal-opcode flag.
// Optional feature macro: LOGIC_PIPE_ROTATE_EN (enables ROL/ROR opcodes).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload until the transfer; ready may
// depend combinationally on the downstream ready (in_ready follows
// out_ready), but valid never depends on ready. Outputs are held stable
// while out_valid && !out_ready and are forced to zero when out_valid is low.
module logic_pipe_unit
  import logic_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic              zero,
  output logic              illegal,
  output logic              busy
);

  // Stage 1: captured operands.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [OP_W-1:0]   s1_op;

  // Stage 2: decoded result.
  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic              s2_zero;
  logic              s2_illegal;

  // Core outputs for the entry currently in S1.
  logic [DATA_W-1:0] core_result;
  logic              core_illegal;

  // Pipeline advance controls.
  logic s2_adv;
  logic s1_move;
  logic in_fire;

  lu_logic_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .a       (s1_a),
    .b       (s1_b),
    .op      (s1_op),
    .result  (core_result),
    .illegal (core_illegal)
  );

  // S2 can take a new entry when empty or being drained; S1 drains into it.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_move  = s1_valid && s2_adv;
    in_ready = !s1_valid || s1_move;
    in_fire  = in_valid && in_ready;
  end

  // S1 register: load on accept, clear when its entry moves on with no refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2 register: only changes when allowed to advance, which keeps the
  // presented result stable during output backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= core_result;
        s2_zero    <= (core_result == '0);
        s2_illegal <= core_illegal;
      end
    end
  end

  // Output drive: zero-extend to OUT_W and gate everything with out_valid.
  always_comb begin
    out_valid = s2_valid;
    result    = '0;
    if (s2_valid) begin
      result[DATA_W-1:0] = s2_result;
    end
    zero    = s2_valid && s2_zero;
    illegal = s2_valid && s2_illegal;
    busy    = s1_valid || s2_valid;
  end

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Testbench for logic_pipe_unit: directed vectors, backpressure, random
// traffic and mid-flight reset, checked by a queue-based scoreboard.
// Optional feature macro: LOGIC_PIPE_ROTATE_EN (must match the RTL build).
module tb_logic_pipe_unit;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int EW = OW + 2;  // {illegal, zero, result}

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] result;
  logic          zero;
  logic          illegal;
  logic          busy;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  logic          prev_stall;
  logic [EW-1:0] prev_out;
  logic          rand_done;

  logic_pipe_unit #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: bit-by-bit rotation, plain operators for logic ops.
  function automatic logic [EW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [2:0] o);
    logic [DW-1:0] r;
    logic          ill;
    int            amt;
    r   = '0;
    ill = 1'b0;
    amt = 0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = ~(x & y);
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      default: begin
`ifdef LOGIC_PIPE_ROTATE_EN
        amt = int'(y) % DW;
        for (int i = 0; i < DW; i++) begin
          if (o == 3'd6) r[(i + amt) % DW] = x[i];
          else           r[(i - amt + DW) % DW] = x[i];
        end
`else
        r   = '0;
        ill = 1'b1;
`endif
      end
    endcase
    return {ill, (r == '0), 8'h00, r};
  endfunction

  // Driver: present a transaction, push the expectation on acceptance.
  task automatic send(input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                      input logic [2:0] xo, input logic [EW-1:0] xexp);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a  = xa;
    b  = xb;
    op = xo;
    forever begin
      #4;
      if (in_ready) begin
        exp_q.push_back(xexp);
        @(posedge clk);
        break;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n > 1000) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic send_rand();
    logic [DW-1:0] xa;
    logic [DW-1:0] xb;
    logic [2:0]    xo;
    xa = DW'($urandom);
    xb = DW'($urandom);
    xo = 3'($urandom_range(0, 7));
    send(xa, xb, xo, model(xa, xb, xo));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor / scoreboard: sampled 1ns before each rising edge.
  initial begin
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'({illegal, zero, result}), 64'(prev_out));
        end
        if (!out_valid) begin
          chk("idle_outputs", 64'({illegal, zero, result}), 64'd0);
        end else if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'({illegal, zero, result}), 64'd0);
            total++;
            bad++;
            $display("FAIL unexpected_output: out_valid with empty queue at %0t", $time);
          end else begin
            chk("result", 64'({illegal, zero, result}), 64'(exp_q.pop_front()));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {illegal, zero, result};
      end
    end
  end

  // Main sequence
  initial begin
    logic saw_low;
    int   stale;
    total     = 0;
    bad       = 0;
    rand_done = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({illegal, zero, result}), 64'd0);

    // NAND vector with latency check.
    out_ready = 1'b1;
    send(8'hF0, 8'h3C, 3'b010, {1'b0, 1'b0, 16'h00CF});
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    chk("latency_c1", 64'(out_valid), 64'd0);
    chk("busy_in_flight", 64'(busy), 64'd1);
    @(negedge clk);
    #4;
    chk("latency_c2", 64'(out_valid), 64'd1);
    drain();

    // AND to zero, XOR to all-ones, rotate / illegal.
    send(8'hAA, 8'h55, 3'b000, {1'b0, 1'b1, 16'h0000});
    send(8'hAA, 8'h55, 3'b100, {1'b0, 1'b0, 16'h00FF});
`ifdef LOGIC_PIPE_ROTATE_EN
    send(8'h81, 8'h09, 3'b110, {1'b0, 1'b0, 16'h0003});
    send(8'h81, 8'h09, 3'b111, {1'b0, 1'b0, 16'h00C0});
    send(8'h5A, 8'h08, 3'b110, {1'b0, 1'b0, 16'h005A});
`else
    send(8'h81, 8'h09, 3'b110, {1'b1, 1'b1, 16'h0000});
    send(8'h81, 8'h09, 3'b111, {1'b1, 1'b1, 16'h0000});
`endif
    send(8'h00, 8'h00, 3'b011, {1'b0, 1'b0, 16'h00FF});
    send(8'h0F, 8'hF0, 3'b101, {1'b0, 1'b1, 16'h0000});
    idle(1);
    drain();

    // Backpressure: 4 back-to-back, stall 3 cycles after first out_valid.
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
        idle(1);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        #4;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          #4;
          n++;
        end
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
          #4;
          if (!in_ready) saw_low = 1'b1;
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_in_ready_low", 64'(saw_low), 64'd1);
    drain();

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b001, model(8'h12, 8'h34, 3'b001));
    send(8'h56, 8'h78, 3'b100, model(8'h56, 8'h78, 3'b100));
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      #4;
      if (out_valid) stale++;
    end
    chk("no_stale_output", 64'(stale), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Pipe still works after reset.
    send(8'hC3, 8'h3C, 3'b001, {1'b0, 1'b0, 16'h00FF});
    idle(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_pipe_unit.md
LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width (2..64).
REQ-002 SHALL have parameter OUT_W, default 16, meaning result width (>= DATA_W).
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1: input handshake.
REQ-006 SHALL have ports a in DATA_W, b in DATA_W, op in 3: operands and opcode.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1: output handshake.
REQ-008 SHALL have ports result out OUT_W, zero out 1, illegal out 1: result, result-is-zero, unsupported opcode.
REQ-009 SHALL have port busy out 1: any pipeline stage holds a valid entry.

Function
REQ-010 SHALL implement op codes: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 ROL, 111 ROR.
REQ-011 SHALL compute all results at DATA_W bits and zero-extend to OUT_W; upper bits are never 1.
REQ-012 SHALL rotate a by b[clog2(DATA_W)-1:0] modulo DATA_W; amount 0 returns a unchanged.
REQ-013 SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-014 SHALL be a 2-stage pipeline: S1 registers a/b/op, S2 registers result/zero/illegal; latency 2 cycles from accept to out_valid with out_ready high.
REQ-015 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-016 SHALL advance S2 when !out_valid || out_ready; S1 moves into S2 when S1 valid and S2 advances.
REQ-017 SHALL drive in_ready = !S1_valid || S1 moving; combinational from out_ready permitted.
REQ-018 SHALL hold result, zero, illegal stable while out_valid && !out_ready.
REQ-019 SHALL never drop or duplicate a transaction; results leave in acceptance order.
REQ-020 SHALL assert zero iff the DATA_W result equals 0, qualified by out_valid.
REQ-021 SHALL drive result, zero, illegal to 0 when out_valid is low.

Reset
REQ-022 SHALL on rst low clear S1/S2 valid, result, zero, illegal; out_valid=0, busy=0, in_ready=1 after release.
REQ-023 SHALL discard in-flight entries on reset mid-operation, with no output after release.

Configuration
REQ-024 SHALL compile rotate ops 110/111 only when LOGIC_PIPE_ROTATE_EN is defined.
REQ-025 SHALL, without LOGIC_PIPE_ROTATE_EN, return result 0, zero=1, illegal=1 for op 110/111, still a normal transfer; illegal otherwise always 0.

Structure
REQ-026 SHALL place the opcode enum and opcode width constant in shared package logic_pipe_pkg.
REQ-027 SHALL use one sub-module lu_logic_core: combinational op decode producing result and illegal at DATA_W.

Verification
REQ-028 SHALL cover: DATA_W=8, a=8'hF0, b=8'h3C, op=010, out_ready=1 -> 2 cycles later result=16'h00CF, zero=0.
REQ-029 SHALL cover: a=8'hAA, b=8'h55, op=000 -> result=0, zero=1; op=100 -> result=16'h00FF.
REQ-030 SHALL cover: ROTATE_EN, a=8'h81, b=8'h09, op=110 -> result=16'h0003 (amount 1); without macro -> result=0, illegal=1.
REQ-031 SHALL cover: back-to-back 4 inputs, out_ready low for 3 cycles after first out_valid -> in_ready low once both stages are full, outputs held stable, all 4 in order.
REQ-032 SHALL cover: rst asserted with 2 entries in flight -> out_valid=0, busy=0 immediately, no stale output after release.
